// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by the fetch top level and its skid buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    HOLD,
    FETCH,
    DROP
  } state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JR,
    RD_JUMP
  } redir_t;

  localparam int unsigned PC_INCR = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Oldest instruction wins: EX branch, then ID jump-register, then jump.
  function automatic redir_t redir_pick(
    input logic br,
    input logic jr,
    input logic j
  );
    redir_t sel;
    sel = RD_NONE;
    priority case (1'b1)
      br:      sel = RD_BRANCH;
      jr:      sel = RD_JR;
      j:       sel = RD_JUMP;
      default: sel = RD_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry pc+instruction holding slot for words that land while
// the decode stage is stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_instr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_instr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: pc register, imem req/ack handshake,
// redirect arbitration, stale-fetch discard and IF/ID flush.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
  parameter int                HOLD_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              JumpRegister,
  input  logic [ADDR_W-1:0] JumpRegisterTarget,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic              flush_out
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tgt;
  logic [3:0]        r_cnt;
  logic              r_req;
  logic [ADDR_W-1:0] r_pc_out;
  logic [31:0]       r_instr;
  logic              r_valid;
  logic              r_flush;

  redir_t            w_sel;
  logic              w_redir;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_tgt_al;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_ack;
  logic              w_sk_load;
  logic              w_sk_drain;
  logic              w_sk_clear;
  logic              w_sk_valid;
  logic [ADDR_W-1:0] w_sk_pc;
  logic [31:0]       w_sk_instr;

  assign w_sel    = redir_pick(BranchTaken, JumpRegister, Jump);
  assign w_redir  = (w_sel != RD_NONE);
  assign w_tgt_al = {w_tgt[ADDR_W-1:2], 2'b00};
  assign w_pc_inc = r_pc + ADDR_W'(PC_INCR);
  assign w_ack    = r_req & imem_ack;

  always_comb begin
    w_tgt = '0;
    unique case (w_sel)
      RD_BRANCH: w_tgt = BranchTarget;
      RD_JR:     w_tgt = JumpRegisterTarget;
      RD_JUMP:   w_tgt = JumpTarget;
      default:   w_tgt = '0;
    endcase
  end

  always_comb begin
    w_sk_clear = 1'b0;
    w_sk_load  = 1'b0;
    w_sk_drain = 1'b0;
    if (r_state != HOLD) begin
      w_sk_clear = w_redir;
    end
    if (r_state == FETCH && !w_redir) begin
      w_sk_load  = w_ack & Stall;
      w_sk_drain = !r_req & !Stall & w_sk_valid;
    end
  end

  fetch_skid_buffer #(
    .ADDR_W(ADDR_W)
  ) u_skid (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_load (w_sk_load),
    .i_drain(w_sk_drain),
    .i_clear(w_sk_clear),
    .i_pc   (r_pc),
    .i_instr(imem_rdata),
    .o_valid(w_sk_valid),
    .o_pc   (w_sk_pc),
    .o_instr(w_sk_instr)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= HOLD;
      r_pc     <= RESET_PC;
      r_tgt    <= RESET_PC;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_pc_out <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_flush  <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      unique case (r_state)
        HOLD: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(HOLD_CYCLES - 1)) begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (w_redir) begin
            r_flush <= 1'b1;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            // Unanswered request must run to its ack at the old address.
            if (r_req && !imem_ack) begin
              r_state <= DROP;
              r_tgt   <= w_tgt_al;
            end else begin
              r_pc <= w_tgt_al;
            end
          end else if (w_ack) begin
            r_pc <= w_pc_inc;
            if (!Stall) begin
              r_pc_out <= r_pc;
              r_instr  <= imem_rdata;
              r_valid  <= 1'b1;
              r_req    <= 1'b1;
            end else begin
              r_req <= 1'b0;
            end
          end else if (r_req) begin
            if (!Stall) begin
              r_valid <= 1'b0;
            end
          end else if (!Stall) begin
            r_req <= 1'b1;
            if (w_sk_valid) begin
              r_pc_out <= w_sk_pc;
              r_instr  <= w_sk_instr;
              r_valid  <= 1'b1;
            end else begin
              r_valid <= 1'b0;
            end
          end
        end
        DROP: begin
          if (w_redir) begin
            r_flush <= 1'b1;
            r_valid <= 1'b0;
            if (imem_ack) begin
              r_pc    <= w_tgt_al;
              r_state <= FETCH;
            end else begin
              r_tgt <= w_tgt_al;
            end
          end else if (imem_ack) begin
            r_pc    <= r_tgt;
            r_state <= FETCH;
          end
        end
        default: r_state <= HOLD;
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc_out;
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign flush_out   = r_flush;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, multi-cycle
// corner sequences and randomized run against a program-order model.
module tb_fetch_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        JumpRegister;
  logic [31:0] JumpRegisterTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        flush_out;

  fetch_sequencer dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Stall             (Stall),
    .BranchTaken       (BranchTaken),
    .BranchTarget      (BranchTarget),
    .Jump              (Jump),
    .JumpTarget        (JumpTarget),
    .JumpRegister      (JumpRegister),
    .JumpRegisterTarget(JumpRegisterTarget),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .pc_out            (pc_out),
    .instr_out         (instr_out),
    .instr_valid       (instr_valid),
    .flush_out         (flush_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory model: ack after m_lat cycles of a held request
  int fixed_lat;
  int m_cnt;
  int m_lat;

  function automatic int pick_lat();
    if (fixed_lat != 0) return fixed_lat;
    return int'($urandom_range(1, 3));
  endfunction

  assign imem_ack   = imem_req && (m_cnt + 1 >= m_lat);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_cnt <= 0;
      m_lat <= pick_lat();
    end else if (imem_req && imem_ack) begin
      m_cnt <= 0;
      m_lat <= pick_lat();
    end else if (imem_req) begin
      m_cnt <= m_cnt + 1;
    end
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic        p_req;
  logic        p_ack;
  logic [31:0] p_addr;

  task automatic step(input logic st, input logic br, input logic jr,
                      input logic j, input logic [31:0] bt,
                      input logic [31:0] jrt, input logic [31:0] jt);
    Stall              = st;
    BranchTaken        = br;
    BranchTarget       = bt;
    JumpRegister       = jr;
    JumpRegisterTarget = jrt;
    Jump               = j;
    JumpTarget         = jt;
    #1;
    p_req  = imem_req;
    p_ack  = imem_ack;
    p_addr = imem_addr;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input int lat);
    fixed_lat = lat;
    Reset     = 1'b1;
    Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; JumpRegister = 1'b0;
    BranchTarget = '0; JumpTarget = '0; JumpRegisterTarget = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  typedef struct {
    logic        st, br, jr, j;
    logic [31:0] bt, jrt, jt;
    logic        e_req;
    logic [31:0] e_addr, e_pc;
    logic        e_v, e_f;
  } vec_t;

  function automatic vec_t v(
    input logic st, input logic br, input logic jr, input logic j,
    input logic [31:0] bt, input logic [31:0] jrt, input logic [31:0] jt,
    input logic er, input logic [31:0] ea, input logic [31:0] ep,
    input logic ev, input logic ef);
    vec_t r;
    r.st = st; r.br = br; r.jr = jr; r.j = j;
    r.bt = bt; r.jrt = jrt; r.jt = jt;
    r.e_req = er; r.e_addr = ea; r.e_pc = ep; r.e_v = ev; r.e_f = ef;
    return r;
  endfunction

  vec_t        tbl[21];
  logic [31:0] exp_pc;
  logic [31:0] tg;
  logic [31:0] pv_pc, pv_in;
  logic        pv_v;
  logic        st, br, jr, j;
  logic [31:0] bt, jrt, jt;
  logic        done;
  int          n_del;

  initial begin
    n_chk = 0; n_fail = 0; n_del = 0;
    Reset = 1'b1;
    Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; JumpRegister = 1'b0;
    BranchTarget = '0; JumpTarget = '0; JumpRegisterTarget = '0;

    // {stall,br,jr,j, bt,jrt,jt} -> {req,addr,pc_out,valid,flush}
    tbl[0]  = v(0,0,0,1, 0,0,'h80,       0,'h0,'h0,0,0);
    tbl[1]  = v(0,0,0,0, 0,0,0,          0,'h0,'h0,0,0);
    tbl[2]  = v(0,0,0,0, 0,0,0,          1,'h0,'h0,0,0);
    tbl[3]  = v(0,0,0,0, 0,0,0,          1,'h4,'h0,1,0);
    tbl[4]  = v(0,0,0,0, 0,0,0,          1,'h8,'h4,1,0);
    tbl[5]  = v(0,0,0,0, 0,0,0,          1,'hC,'h8,1,0);
    tbl[6]  = v(0,0,0,0, 0,0,0,          1,'h10,'hC,1,0);
    tbl[7]  = v(0,1,0,1, 'h40,0,'h80,    1,'h40,'hC,0,1);
    tbl[8]  = v(0,0,0,0, 0,0,0,          1,'h44,'h40,1,0);
    tbl[9]  = v(0,0,0,0, 0,0,0,          1,'h48,'h44,1,0);
    tbl[10] = v(1,0,0,0, 0,0,0,          0,'h4C,'h44,1,0);
    tbl[11] = v(1,0,0,0, 0,0,0,          0,'h4C,'h44,1,0);
    tbl[12] = v(0,0,0,0, 0,0,0,          1,'h4C,'h48,1,0);
    tbl[13] = v(0,0,0,0, 0,0,0,          1,'h50,'h4C,1,0);
    tbl[14] = v(0,0,1,1, 0,'h23,'h80,    1,'h20,'h4C,0,1);
    tbl[15] = v(0,0,0,0, 0,0,0,          1,'h24,'h20,1,0);
    tbl[16] = v(0,1,1,0, 'h60,'h90,0,    1,'h60,'h20,0,1);
    tbl[17] = v(0,0,0,0, 0,0,0,          1,'h64,'h60,1,0);
    tbl[18] = v(0,1,0,0, 'hFFFF_FFFC,0,0, 1,'hFFFF_FFFC,'h60,0,1);
    tbl[19] = v(0,0,0,0, 0,0,0,          1,'h0,'hFFFF_FFFC,1,0);
    tbl[20] = v(0,0,0,0, 0,0,0,          1,'h4,'h0,1,0);

    // zero-wait memory: reset state then vector table
    fixed_lat = 1;
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst req", {31'b0, imem_req}, 32'h0);
    chk("rst addr", imem_addr, 32'h0);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst instr", instr_out, 32'h0);
    chk("rst valid", {31'b0, instr_valid}, 32'h0);
    chk("rst flush", {31'b0, flush_out}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].st, tbl[i].br, tbl[i].jr, tbl[i].j,
           tbl[i].bt, tbl[i].jrt, tbl[i].jt);
      chk($sformatf("row%0d req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("row%0d addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d pc_out", i), pc_out, tbl[i].e_pc);
      chk($sformatf("row%0d valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_v});
      chk($sformatf("row%0d flush", i), {31'b0, flush_out}, {31'b0, tbl[i].e_f});
      if (tbl[i].e_v)
        chk($sformatf("row%0d instr", i), instr_out, mem_word(tbl[i].e_pc));
    end

    // 3-cycle memory: jump while fetch of 0x8 is outstanding
    do_reset(3);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (imem_req && imem_addr == 32'h8) done = 1'b1;
      else idle();
    end
    chk("wait req 8", {31'b0, done}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h100);
    chk("drop flush", {31'b0, flush_out}, 32'h1);
    chk("drop req", {31'b0, imem_req}, 32'h1);
    chk("drop addr", imem_addr, 32'h8);
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      idle();
      chk("drop valid", {31'b0, instr_valid}, 32'h0);
      chk("drop flush off", {31'b0, flush_out}, 32'h0);
      chk("drop req held", {31'b0, imem_req}, 32'h1);
      if (p_ack) begin
        chk("post drop addr", imem_addr, 32'h100);
        done = 1'b1;
      end else begin
        chk("drop addr held", imem_addr, 32'h8);
      end
    end
    chk("drop ack seen", {31'b0, done}, 32'h1);
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      idle();
      if (instr_valid) done = 1'b1;
    end
    chk("tgt valid seen", {31'b0, done}, 32'h1);
    chk("tgt pc_out", pc_out, 32'h100);
    chk("tgt instr", instr_out, mem_word(32'h100));

    // randomized run against program-order model
    do_reset(0);
    exp_pc = 32'h0;
    pv_pc = pc_out; pv_in = instr_out; pv_v = instr_valid;
    for (int i = 0; i < 1500; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = (i >= 4) && ($urandom_range(0, 15) == 0);
      jr  = (i >= 4) && ($urandom_range(0, 15) == 0);
      j   = (i >= 4) && ($urandom_range(0, 15) == 0);
      bt  = $urandom; jrt = $urandom; jt = $urandom;
      step(st, br, jr, j, bt, jrt, jt);
      if (br || jr || j) begin
        tg = br ? bt : (jr ? jrt : jt);
        exp_pc = tg & 32'hFFFF_FFFC;
        chk("rnd flush", {31'b0, flush_out}, 32'h1);
        chk("rnd redir valid", {31'b0, instr_valid}, 32'h0);
      end else begin
        chk("rnd flush off", {31'b0, flush_out}, 32'h0);
        if (!st) begin
          if (instr_valid) begin
            chk("rnd pc_out", pc_out, exp_pc);
            chk("rnd instr", instr_out, mem_word(exp_pc));
            exp_pc = exp_pc + 32'h4;
            n_del++;
          end
        end else begin
          chk("rnd hold pc", pc_out, pv_pc);
          chk("rnd hold instr", instr_out, pv_in);
          chk("rnd hold valid", {31'b0, instr_valid}, {31'b0, pv_v});
        end
      end
      if (p_req && !p_ack) begin
        chk("rnd req kept", {31'b0, imem_req}, 32'h1);
        chk("rnd addr kept", imem_addr, p_addr);
      end
      pv_pc = pc_out; pv_in = instr_out; pv_v = instr_valid;
    end
    chk("rnd progress", {31'b0, n_del > 100}, 32'h1);

    // asynchronous reset while a request is up
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (imem_req && instr_valid) done = 1'b1;
      else idle();
    end
    chk("pre-reset req", {31'b0, done}, 32'h1);
    Reset = 1'b1;
    #1;
    chk("async req", {31'b0, imem_req}, 32'h0);
    chk("async valid", {31'b0, instr_valid}, 32'h0);
    chk("async addr", imem_addr, 32'h0);
    chk("async pc_out", pc_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the instruction-fetch stage of the single-issue pipeline: owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents fetched words to the IF/ID register. It arbitrates simultaneous redirect sources (taken branch, jump, jump-register) and hazard stalls. Where a redirect makes data from an in-flight fetch stale, it discards that data and flushes the IF/ID register.

## Interface
Parameters:
- ADDR_W, 32, PC and instruction-memory address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- HOLD_CYCLES, 2, idle cycles after reset release before the first request (1..15)

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hazard unit holds the IF/ID outputs
- BranchTaken  in  1  taken branch, resolved in EX
- BranchTarget  in  ADDR_W  branch target
- Jump  in  1  jump, resolved in ID
- JumpTarget  in  ADDR_W  jump target
- JumpRegister  in  1  jump-register, resolved in ID
- JumpRegisterTarget  in  ADDR_W  jump-register target
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  memory returns data this cycle; may coincide with the first req cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- pc_out  out  ADDR_W  address of instr_out
- instr_out  out  32  fetched instruction
- instr_valid  out  1  instr_out holds a live instruction
- flush_out  out  1  one-cycle pulse; IF/ID must squash its contents

## Operation
- States:
  - HOLD: post-reset idle.
  - FETCH: request issued, or ready to issue.
  - DROP: request outstanding whose data is stale.
- Reset values:
  - state=HOLD, pc=RESET_PC, hold counter=0.
  - imem_req=0, imem_addr=RESET_PC.
  - pc_out=0, instr_out=0, instr_valid=0, flush_out=0.
  - Skid buffer empty.
- HOLD: count HOLD_CYCLES rising edges after Reset deasserts, then move to FETCH. Redirects are ignored in HOLD.
- FETCH:
  - imem_req=1 when (Stall=0 and skid buffer empty) or a request is already outstanding.
  - imem_addr is always the current pc.
  - Once raised, imem_req must not drop before imem_ack, even if Stall rises.
- On imem_ack with no redirect:
  - pc <= pc+4, wrapping mod 2^ADDR_W.
  - If Stall=0, the word and its pc go to the outputs with instr_valid=1.
  - If Stall=1, the word and its pc go to the skid buffer.
- With Stall=1, the outputs hold their values.
- When Stall falls with the skid buffer full: the buffer drains to the outputs first, and a new request issues in the same cycle.
- If Stall=0 and no ack arrives, instr_valid <= 0.
- Redirect priority: BranchTaken > JumpRegister > Jump, because the oldest instruction wins. The target's low 2 bits are forced to 0.
- On a redirect in FETCH or DROP:
  - pc <= selected target.
  - flush_out=1 for the next cycle only; instr_valid <= 0.
  - Skid buffer is cleared.
  - Stall is overridden.
- If a request is outstanding without an ack in the redirect cycle, go to DROP. In DROP, keep imem_req high at the old address until ack, discard the data, then return to FETCH with the new pc.
- If ack coincides with the redirect, discard the data and stay in FETCH.
- A second redirect arriving in DROP replaces the pending target and pulses flush_out again.
- Asserting Reset mid-operation forces all reset values immediately, including dropping imem_req. Any outstanding transaction is abandoned.

## Timing
- Zero-wait memory (ack in the same cycle as req): a request in cycle N gives instr_valid=1 in N+1. Sustained throughput is one instruction per cycle.
- First request after reset: imem_req=1 in cycle HOLD_CYCLES+1 after Reset deasserts.
- Redirect sampled at edge N:
  - flush_out=1 during cycle N+1.
  - imem_addr=target in N+1, or in the cycle after the stale ack if in DROP.
  - First valid target instruction in N+2 with zero-wait memory.
- All outputs are registered. imem_req and imem_addr come straight from state and pc.

## Structure
- Shared package fetch_pkg holds:
  - State enum {HOLD, FETCH, DROP}.
  - PC_INCR=4.
  - Redirect-select encoding.
  - RESET_PC default.
- One sub-module: fetch_skid_buffer, a one-entry pc+instruction buffer with load, drain and clear.
- The FSM, redirect mux and pc register stay in the top level.

## Test plan
- Reset then zero-wait memory with HOLD_CYCLES=2 -> imem_req rises 3 cycles after release; pc_out sequence is 0,4,8,C with instr_valid=1 every cycle.
- BranchTaken=1 and Jump=1 in the same cycle, targets 0x40 and 0x80 -> imem_addr=0x40, flush_out high for exactly one cycle, next pc_out=0x40.
- Memory with 3-cycle ack latency and Jump to 0x100 while a fetch of 0x8 is outstanding -> req held at 0x8 until ack, data discarded, then a request at 0x100; pc_out never shows 0x8.
- Stall rises as an ack for 0xC arrives -> outputs hold the 0x8 instruction; when Stall drops, pc_out=0xC without re-fetching; then 0x10 follows.
- JumpRegisterTarget=0x23 -> imem_addr=0x20; a fetch at pc=0xFFFF_FFFC is followed by a fetch at 0x0.
- Reset asserted while imem_req=1 -> imem_req=0, instr_valid=0 and pc=RESET_PC asynchronously, before the next clock edge.
